paillier_ctrl_seq: RTL and testbench

Parametrised sequencer for an encrypted (Paillier, Montgomery-domain) state-feedback controller over NUM_CH measured channels. It issues a task-dependent micro-program of modular-exponentiation and multiplication operations to an external modexp engine, keeps per-channel encrypted setpoints and a running ciphertext accumulator, and returns the encrypted control input. It sits between the plant I/O sampling logic and the shared modexp engine, and generalises the fixed two-channel inverted-pendulum controller to any channel count with runtime gains, error reporting and reset.

---
 rtl/paillier_ctrl_seq_if.sv | 21 ++
 rtl/paillier_ctrl_seq.sv | 212 +++++++++++++++++++++
 tb/tb_paillier_ctrl_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/paillier_ctrl_seq_if.sv
// Engine-side bus between the Paillier sequencer and the shared modexp engine.
interface paillier_ctrl_seq_if #(
  parameter int unsigned DATA_W = 528
);
  logic              me_start;
  logic              me_mode;    // 0 = base^exp, 1 = base*exp
  logic [DATA_W-1:0] me_base;
  logic [DATA_W-1:0] me_exp;
  logic              me_done;
  logic [DATA_W-1:0] me_result;

  modport master (
    output me_start, me_mode, me_base, me_exp,
    input  me_done, me_result
  );

  modport slave (
    input  me_start, me_mode, me_base, me_exp,
    output me_done, me_result
  );
endinterface

// File: rtl/paillier_ctrl_seq.sv
// Sequencer for an encrypted (Paillier, Montgomery-domain) state-feedback controller.
// Issues per-channel modexp/multiply micro-programs to an external engine, keeps
// encrypted setpoints and a ciphertext accumulator, and returns the accumulator.
module paillier_ctrl_seq #(
  parameter int unsigned       NUM_CH    = 2,
  parameter int unsigned       DATA_W    = 528,
  parameter int unsigned       GAIN_W    = 32,
  parameter logic [DATA_W-1:0] N_MONT    = '0,
  parameter logic [DATA_W-1:0] R2_MOD_N2 = '0,
  parameter logic [DATA_W-1:0] R_MOD_N2  = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               task_i,
  input  logic [NUM_CH*DATA_W-1:0] meas_flat_i,
  input  logic [NUM_CH*GAIN_W-1:0] gain_flat_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [DATA_W-1:0]        result_o,
  paillier_ctrl_seq_if.master      eng_io
);

  localparam int unsigned    ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    TaskSetpoint = 2'b00,
    TaskControl  = 2'b01,
    TaskClearAcc = 2'b10,
    TaskRsvd     = 2'b11
  } task_e;

  typedef enum logic [2:0] {StIdle, StLatch, StIssue, StWait, StFinish} state_e;

  state_e            state_q;
  logic [1:0]        task_q;
  logic [ChW-1:0]    ch_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] meas_q [NUM_CH];
  logic [GAIN_W-1:0] gain_q [NUM_CH];
  logic [DATA_W-1:0] sp_q   [NUM_CH];
  logic [DATA_W-1:0] tmp_q;
  logic [DATA_W-1:0] acc_q;
  logic              busy_q, done_q, err_q;
  logic              me_start_q, me_mode_q;
  logic [DATA_W-1:0] me_base_q, me_exp_q;

  logic              last_op, last_ch;
  logic [1:0]        nxt_op;
  logic [ChW-1:0]    nxt_ch;
  logic [ChW-1:0]    iss_ch;
  logic [1:0]        iss_op;
  logic [DATA_W-1:0] iss_tmp;
  logic              iss_mode;
  logic [DATA_W-1:0] iss_base, iss_exp;

  // Program position of the next op; from LATCH it is (0,0), from WAIT the advanced one,
  // with the engine result standing in for tmp since tmp_q is only written at that edge.
  always_comb begin
    last_op = (task_q == TaskControl) ? (op_q == 2'd3) : (op_q == 2'd1);
    last_ch = (ch_q == LastCh);
    nxt_op  = last_op ? 2'd0 : op_q + 2'd1;
    nxt_ch  = (last_op && !last_ch) ? ch_q + ChW'(1) : ch_q;
    if (state_q == StWait) begin
      iss_ch  = nxt_ch;
      iss_op  = nxt_op;
      iss_tmp = eng_io.me_result;
    end else begin
      iss_ch  = '0;
      iss_op  = '0;
      iss_tmp = tmp_q;
    end
  end

  // Operand decode for the op about to be issued.
  always_comb begin
    iss_mode = 1'b0;
    iss_base = '0;
    iss_exp  = '0;
    if (task_q == TaskSetpoint) begin
      if (iss_op == 2'd0) begin
        iss_base = meas_q[iss_ch];
        iss_exp  = N_MONT;
      end else begin
        iss_mode = 1'b1;
        iss_base = iss_tmp + DATA_W'(1);  // wraps modulo 2^DATA_W
        iss_exp  = R2_MOD_N2;
      end
    end else begin
      unique case (iss_op)
        2'd0: begin
          iss_base = meas_q[iss_ch];
          iss_exp  = '1;  // all-ones exponent negates the plaintext
        end
        2'd1: begin
          iss_mode = 1'b1;
          iss_base = iss_tmp;
          iss_exp  = sp_q[iss_ch];
        end
        2'd2: begin
          iss_base = iss_tmp;
          iss_exp  = DATA_W'(gain_q[iss_ch]);
        end
        2'd3: begin
          iss_mode = 1'b1;
          iss_base = iss_tmp;
          iss_exp  = acc_q;
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      task_q     <= '0;
      ch_q       <= '0;
      op_q       <= '0;
      tmp_q      <= '0;
      acc_q      <= R_MOD_N2;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      me_start_q <= 1'b0;
      me_mode_q  <= 1'b0;
      me_base_q  <= '0;
      me_exp_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        meas_q[c] <= '0;
        gain_q[c] <= '0;
        sp_q[c]   <= '0;
      end
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      me_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // done_q still high means FINISH just left; hold off one cycle.
          if (start_i && !done_q) begin
            task_q <= task_i;
            ch_q   <= '0;
            op_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              meas_q[c] <= meas_flat_i[c*DATA_W +: DATA_W];
              gain_q[c] <= gain_flat_i[c*GAIN_W +: GAIN_W];
            end
            unique case (task_i)
              TaskRsvd: err_q <= 1'b1;
              TaskClearAcc: begin
                acc_q   <= R_MOD_N2;
                busy_q  <= 1'b1;
                state_q <= StFinish;
              end
              default: begin
                busy_q  <= 1'b1;
                state_q <= StLatch;
              end
            endcase
          end
        end
        StLatch: begin
          if (task_q == TaskControl) acc_q <= R_MOD_N2;
          me_start_q <= 1'b1;
          me_mode_q  <= iss_mode;
          me_base_q  <= iss_base;
          me_exp_q   <= iss_exp;
          state_q    <= StIssue;
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (eng_io.me_done) begin
            tmp_q <= eng_io.me_result;
            if (task_q == TaskSetpoint && op_q == 2'd1) sp_q[ch_q] <= eng_io.me_result;
            if (task_q == TaskControl && op_q == 2'd3) acc_q <= eng_io.me_result;
            if (last_op && last_ch) begin
              state_q <= StFinish;
            end else begin
              ch_q       <= nxt_ch;
              op_q       <= nxt_op;
              me_start_q <= 1'b1;
              me_mode_q  <= iss_mode;
              me_base_q  <= iss_base;
              me_exp_q   <= iss_exp;
              state_q    <= StIssue;
            end
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign result_o        = acc_q;
  assign eng_io.me_start = me_start_q;
  assign eng_io.me_mode  = me_mode_q;
  assign eng_io.me_base  = me_base_q;
  assign eng_io.me_exp   = me_exp_q;

endmodule

// File: tb/tb_paillier_ctrl_seq.sv
// Bench for paillier_ctrl_seq: behavioural mod-143 engine, op and done scoreboards.
module tb_paillier_ctrl_seq;
  localparam int          NCH   = 3;
  localparam logic [15:0] NMONT = 16'd3;
  localparam logic [15:0] R2    = 16'd4;
  localparam logic [15:0] RMOD  = 16'd9;

  logic clk = 1'b0;
  logic rst;
  logic start_i;
  logic [1:0] task_i;
  logic [NCH*16-1:0] meas_flat, gain_flat;
  logic busy_o, done_o, err_o;
  logic [15:0] result_o;

  paillier_ctrl_seq_if #(.DATA_W(16)) eng_if ();

  paillier_ctrl_seq #(
    .NUM_CH(NCH), .DATA_W(16), .GAIN_W(16),
    .N_MONT(NMONT), .R2_MOD_N2(R2), .R_MOD_N2(RMOD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .task_i(task_i),
    .meas_flat_i(meas_flat), .gain_flat_i(gain_flat),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .eng_io(eng_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] m_exp(input logic [15:0] b, input logic [15:0] e);
    int unsigned r = 1;
    int unsigned x = b % 143;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % 143;
      x = (x * x) % 143;
    end
    return 16'(r);
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    int unsigned r = ((32'(a) % 143) * (32'(b) % 143)) % 143;
    return 16'(r);
  endfunction

  typedef struct {logic [15:0] res; int t; int lat;} done_exp_t;
  logic [32:0] exp_op_q [$];
  done_exp_t   exp_done_q [$];

  logic [15:0] m_meas [NCH] = '{16'd5, 16'd7, 16'd11};
  logic [15:0] m_gain [NCH] = '{16'd2, 16'd3, 16'd5};
  logic [15:0] m_sp   [NCH];
  logic [15:0] m_acc;
  int eng_lat  = 5;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic model_setpoint();
    logic [15:0] t;
    for (int c = 0; c < NCH; c++) begin
      exp_op_q.push_back({1'b0, m_meas[c], NMONT});
      t = m_exp(m_meas[c], NMONT) + 16'd1;
      exp_op_q.push_back({1'b1, t, R2});
      m_sp[c] = m_mul(t, R2);
    end
  endtask

  task automatic model_control();
    logic [15:0] t;
    logic [15:0] a = RMOD;
    for (int c = 0; c < NCH; c++) begin
      exp_op_q.push_back({1'b0, m_meas[c], 16'hFFFF});
      t = m_exp(m_meas[c], 16'hFFFF);
      exp_op_q.push_back({1'b1, t, m_sp[c]});
      t = m_mul(t, m_sp[c]);
      exp_op_q.push_back({1'b0, t, m_gain[c]});
      t = m_exp(t, m_gain[c]);
      exp_op_q.push_back({1'b1, t, a});
      a = m_mul(t, a);
    end
    m_acc = a;
  endtask

  function automatic int lat_of(input logic [1:0] tk);
    if (tk == 2'b00) return 2 + 2 * NCH * (eng_lat + 1) + 1;
    if (tk == 2'b01) return 2 + 4 * NCH * (eng_lat + 1) + 1;
    return 2;
  endfunction

  // Called at a negedge; start is sampled at the next rising edge.
  task automatic issue(input logic [1:0] tk, input bit hold);
    if (tk == 2'b00) model_setpoint();
    else if (tk == 2'b01) model_control();
    else m_acc = RMOD;
    exp_done_q.push_back('{m_acc, cyc + 1, lat_of(tk)});
    task_i  = tk;
    start_i = 1'b1;
    @(negedge clk);
    check_val("busy_after_start", busy_o, 1);
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done();
    int target = done_cnt + 1;
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("done_seen", done_cnt >= target, 1);
  endtask

  // Done scoreboard: values seen at negedge after edge k are those sampled at edge k+1.
  always @(negedge clk) begin
    if (done_o) begin
      done_exp_t e;
      done_cnt++;
      done_cyc = cyc;
      check_val("done_expected", exp_done_q.size() != 0, 1);
      if (exp_done_q.size() != 0) begin
        e = exp_done_q.pop_front();
        check_val("result", result_o, e.res);
        check_val("latency", cyc + 1 - e.t, e.lat);
      end
      check_val("busy_at_done", busy_o, 0);
    end
  end

  // Model engine: checks each issued op against the op scoreboard, answers after eng_lat.
  initial begin : engine
    logic [32:0] got_op;
    logic [32:0] want;
    bit stable, rst_hit;
    eng_if.me_done   = 1'b0;
    eng_if.me_result = '0;
    @(negedge clk);
    forever begin
      if (eng_if.me_start && !rst) begin
        got_op = {eng_if.me_mode, eng_if.me_base, eng_if.me_exp};
        check_val("op_expected", exp_op_q.size() != 0, 1);
        if (exp_op_q.size() != 0) begin
          want = exp_op_q.pop_front();
          check_val("op", got_op, want);
        end
        stable  = 1'b1;
        rst_hit = 1'b0;
        repeat (eng_lat) begin
          @(negedge clk);
          if (rst) rst_hit = 1'b1;
          if (eng_if.me_start || {eng_if.me_mode, eng_if.me_base, eng_if.me_exp} != got_op)
            stable = 1'b0;
        end
        if (!rst_hit) check_val("operands_stable", stable, 1);
        eng_if.me_result = got_op[32] ? m_mul(got_op[31:16], got_op[15:0])
                                      : m_exp(got_op[31:16], got_op[15:0]);
        eng_if.me_done = 1'b1;
        @(negedge clk);
        eng_if.me_done = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    task_i  = 2'b00;
    for (int c = 0; c < NCH; c++) begin
      meas_flat[c*16 +: 16] = m_meas[c];
      gain_flat[c*16 +: 16] = m_gain[c];
      m_sp[c] = '0;
    end
    m_acc = RMOD;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_err", err_o, 0);
    check_val("rst_me_start", eng_if.me_start, 0);
    check_val("rst_result", result_o, RMOD);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b10, 1'b0); wait_done();
    issue(2'b00, 1'b0); wait_done();
    issue(2'b01, 1'b0); wait_done();

    // Reserved task: one-cycle err, nothing issued, result kept.
    task_i  = 2'b11;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_val("rsvd_err", err_o, 1);
    check_val("rsvd_busy", busy_o, 0);
    @(negedge clk);
    check_val("rsvd_err_clear", err_o, 0);
    check_val("rsvd_busy2", busy_o, 0);
    check_val("rsvd_result", result_o, m_acc);
    repeat (3) @(negedge clk);

    // start held through CONTROL: runs once, then re-accepted the cycle after done.
    issue(2'b01, 1'b1);
    wait_done();
    model_control();
    exp_done_q.push_back('{m_acc, done_cyc + 2, lat_of(2'b01)});
    while (cyc < done_cyc + 2) @(negedge clk);
    start_i = 1'b0;
    check_val("reaccept_busy", busy_o, 1);
    wait_done();

    // Reset during WAIT, after the first channel has updated the accumulator.
    issue(2'b01, 1'b0);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_op_q.delete();
    exp_done_q.delete();
    m_acc = RMOD;
    for (int c = 0; c < NCH; c++) m_sp[c] = '0;
    check_val("midrst_busy", busy_o, 0);
    check_val("midrst_result", result_o, RMOD);
    repeat (10) @(negedge clk);
    check_val("late_done_busy", busy_o, 0);
    check_val("late_done_result", result_o, RMOD);
    issue(2'b10, 1'b0); wait_done();

    // Engine latency sweep.
    eng_lat = 1;
    issue(2'b00, 1'b0); wait_done();
    issue(2'b01, 1'b0); wait_done();
    repeat (2) @(negedge clk);
    eng_lat = 40;
    issue(2'b00, 1'b0); wait_done();
    issue(2'b01, 1'b0); wait_done();

    repeat (5) @(negedge clk);
    check_val("ops_drained", exp_op_q.size(), 0);
    check_val("dones_drained", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
